// File: rtl/frame_aligner_gen.sv
// Header-based frame aligner: requests gearbox bit slips until LOCK_THR consecutive good headers are seen.
// Define FRAME_ALIGNER_ERRCNT_EN to build the saturating locked-state header error counter.
module frame_aligner_gen #(
  parameter int                FRAME_W     = 256,
  parameter int                HDR_W       = 2,
  parameter logic [HDR_W-1:0]  HDR_PATTERN = 2'b10,
  parameter int                LOCK_THR    = 8,
  parameter int                UNLOCK_THR  = 4,
  parameter int                SLIP_WAIT   = 3,
  parameter int                ERR_W       = 16
) (
  input  logic               clk40MHz_RX,
  input  logic               reset_n,
  input  logic               enable_i,
  input  logic               mode_i,
  input  logic [FRAME_W-1:0] frame_i,
  output logic               bitslip_o,
  output logic               ready_o,
  output logic [FRAME_W-1:0] frame_o,
  output logic               valid_o,
  output logic [7:0]         slip_cnt_o,
  output logic [ERR_W-1:0]   err_cnt_o
);

  typedef enum logic [2:0] {ST_IDLE, ST_CHECK, ST_SLIP, ST_WAIT, ST_LOCKED} state_t;

  localparam logic [7:0]         LOCK_LAST   = 8'(LOCK_THR - 1);
  localparam logic [7:0]         UNLOCK_LAST = 8'(UNLOCK_THR - 1);
  localparam logic [3:0]         WAIT_LOAD   = 4'(SLIP_WAIT);
  localparam logic [FRAME_W-1:0] LOW_MASK    = {{(FRAME_W - FRAME_W/2){1'b0}}, {(FRAME_W/2){1'b1}}};

  state_t             state_q, state_d;
  logic [7:0]         good_q, good_d;
  logic [7:0]         bad_q, bad_d;
  logic [3:0]         wait_q, wait_d;
  logic               bitslip_q, bitslip_d;
  logic               ready_q, ready_d;
  logic               valid_q, valid_d;
  logic               mode_q, mode_d;
  logic [7:0]         slip_q, slip_d;
  logic [FRAME_W-1:0] frame_q, frame_d;
  logic [HDR_W-1:0]   hdr;
  logic               hdr_good;
`ifdef FRAME_ALIGNER_ERRCNT_EN
  logic [ERR_W-1:0]   err_q, err_d;
`endif

  assign hdr      = mode_i ? frame_i[FRAME_W-1 -: HDR_W] : frame_i[FRAME_W/2-1 -: HDR_W];
  assign hdr_good = (hdr == HDR_PATTERN);

  always_comb begin
    state_d   = state_q;
    good_d    = good_q;
    bad_d     = bad_q;
    wait_d    = wait_q;
    bitslip_d = 1'b0;
    ready_d   = ready_q;
    valid_d   = ready_q;
    mode_d    = mode_i;
    slip_d    = bitslip_q ? slip_q + 8'd1 : slip_q;
    frame_d   = mode_i ? frame_i : (frame_i & LOW_MASK);
`ifdef FRAME_ALIGNER_ERRCNT_EN
    err_d     = err_q;
    if (state_q == ST_LOCKED && enable_i && mode_i == mode_q && !hdr_good && err_q != '1)
      err_d = err_q + ERR_W'(1);
`endif
    if (!enable_i) begin
      state_d = ST_IDLE;
      good_d  = '0;
      bad_d   = '0;
      wait_d  = '0;
      ready_d = 1'b0;
    end else if (ready_q && mode_i != mode_q) begin
      // Header position moved under us: restart the lock search.
      state_d = ST_CHECK;
      good_d  = '0;
      bad_d   = '0;
      wait_d  = '0;
      ready_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: state_d = ST_CHECK;
        ST_CHECK: begin
          if (hdr_good) begin
            if (good_q == LOCK_LAST) begin
              state_d = ST_LOCKED;
              good_d  = '0;
              bad_d   = '0;
              ready_d = 1'b1;
            end else begin
              good_d = good_q + 8'd1;
            end
          end else begin
            good_d    = '0;
            state_d   = ST_SLIP;
            bitslip_d = 1'b1;
          end
        end
        ST_SLIP: begin
          if (SLIP_WAIT == 0) begin
            state_d = ST_CHECK;
          end else begin
            wait_d  = WAIT_LOAD;
            state_d = ST_WAIT;
          end
        end
        ST_WAIT: begin
          wait_d = wait_q - 4'd1;
          if (wait_q <= 4'd1) begin
            wait_d  = '0;
            state_d = ST_CHECK;
          end
        end
        ST_LOCKED: begin
          if (hdr_good) begin
            bad_d = '0;
          end else if (bad_q == UNLOCK_LAST) begin
            state_d = ST_CHECK;
            good_d  = '0;
            bad_d   = '0;
            ready_d = 1'b0;
          end else begin
            bad_d = bad_q + 8'd1;
          end
        end
        default: begin
          state_d = ST_IDLE;
          ready_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk40MHz_RX) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      good_q    <= '0;
      bad_q     <= '0;
      wait_q    <= '0;
      bitslip_q <= 1'b0;
      ready_q   <= 1'b0;
      valid_q   <= 1'b0;
      mode_q    <= 1'b0;
      slip_q    <= '0;
      frame_q   <= '0;
`ifdef FRAME_ALIGNER_ERRCNT_EN
      err_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      good_q    <= good_d;
      bad_q     <= bad_d;
      wait_q    <= wait_d;
      bitslip_q <= bitslip_d;
      ready_q   <= ready_d;
      valid_q   <= valid_d;
      mode_q    <= mode_d;
      slip_q    <= slip_d;
      frame_q   <= frame_d;
`ifdef FRAME_ALIGNER_ERRCNT_EN
      err_q     <= err_d;
`endif
    end
  end

  assign bitslip_o  = bitslip_q;
  assign ready_o    = ready_q;
  assign valid_o    = valid_q;
  assign frame_o    = frame_q;
  assign slip_cnt_o = slip_q;
`ifdef FRAME_ALIGNER_ERRCNT_EN
  assign err_cnt_o  = err_q;
`else
  assign err_cnt_o  = '0;
`endif

endmodule

// File: tb/tb_frame_aligner_gen.sv
// Directed bench for frame_aligner_gen with a rotating gearbox model for the misaligned-stream case.
module tb_frame_aligner_gen;

  logic         clk40MHz_RX = 1'b0;
  logic         reset_n     = 1'b0;
  logic         enable_i    = 1'b0;
  logic         mode_i      = 1'b1;
  logic [255:0] frame_i;
  logic         bitslip_o;
  logic         ready_o;
  logic [255:0] frame_o;
  logic         valid_o;
  logic [7:0]   slip_cnt_o;
  logic [15:0]  err_cnt_o;

  localparam logic [255:0] BASE = {2'b10, 254'd0};

  logic [255:0] dir_frame = '0;
  logic         gb_en     = 1'b0;
  int           gb_start  = 0;
  int           sbase     = 0;
  int           gb_off;
  int           cyc       = 0;
  int           slip_seen = 0;
  int           last_slip = 0;
  int           gap_bad   = 0;
  int           errors    = 0;
  int           checks    = 0;
  int           err_scale;
  int           slips_at;

  frame_aligner_gen dut (
    .clk40MHz_RX (clk40MHz_RX),
    .reset_n     (reset_n),
    .enable_i    (enable_i),
    .mode_i      (mode_i),
    .frame_i     (frame_i),
    .bitslip_o   (bitslip_o),
    .ready_o     (ready_o),
    .frame_o     (frame_o),
    .valid_o     (valid_o),
    .slip_cnt_o  (slip_cnt_o),
    .err_cnt_o   (err_cnt_o)
  );

  always #5 clk40MHz_RX = ~clk40MHz_RX;

  function automatic logic [255:0] rotl(input logic [255:0] w, input int k);
    if (k <= 0) return w;
    return (w << k) | (w >> (256 - k));
  endfunction

  // Gearbox model: offset shrinks by one for every slip pulse seen since gb_en was raised.
  always_comb begin
    gb_off = gb_start - (slip_seen - sbase);
    if (gb_off < 0) gb_off = 0;
    frame_i = gb_en ? rotl(BASE, gb_off) : dir_frame;
  end

  always @(posedge clk40MHz_RX) cyc <= cyc + 1;

  always @(negedge clk40MHz_RX) begin
    if (bitslip_o) begin
      if (slip_seen > 0 && (cyc - last_slip) < 4) gap_bad = gap_bad + 1;
      last_slip = cyc;
      slip_seen = slip_seen + 1;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk40MHz_RX);
    #1;
  endtask

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks = checks + 1;
    assert (obs === exp) else begin
      errors = errors + 1;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
`ifdef FRAME_ALIGNER_ERRCNT_EN
    err_scale = 1;
`else
    err_scale = 0;
`endif
    // Reset state
    dir_frame = {8{32'hDEADBEEF}};
    tick(2);
    chk("rst_bitslip", bitslip_o, 0);
    chk("rst_ready", ready_o, 0);
    chk("rst_valid", valid_o, 0);
    chk("rst_frame", frame_o, 0);
    chk("rst_slip", slip_cnt_o, 0);
    chk("rst_err", err_cnt_o, 0);

    // Aligned full frames
    dir_frame = BASE | 256'h0123_4567_89ab_cdef;
    reset_n = 1'b1;
    tick(1);
    chk("idle_ready", ready_o, 0);
    enable_i = 1'b1;
    sbase = slip_seen;
    tick(1);
    for (int i = 1; i <= 8; i++) begin
      tick(1);
      if (i == 7) chk("align_ready_c7", ready_o, 0);
      if (i == 8) chk("align_ready_c8", ready_o, 1);
    end
    chk("align_valid_lag0", valid_o, 0);
    chk("align_frame", frame_o, BASE | 256'h0123_4567_89ab_cdef);
    tick(1);
    chk("align_valid_lag1", valid_o, 1);
    chk("align_no_pulse", slip_seen - sbase, 0);
    chk("align_slip_cnt", slip_cnt_o, 0);

    // Errors while locked
    dir_frame = '0;
    tick(3);
    dir_frame = BASE;
    tick(1);
    chk("err3_ready", ready_o, 1);
    chk("err3_cnt", err_cnt_o, 3 * err_scale);
    dir_frame = '0;
    tick(3);
    chk("bad3_ready", ready_o, 1);
    tick(1);
    chk("bad4_unlock", ready_o, 0);
    chk("bad4_err_cnt", err_cnt_o, 7 * err_scale);

    // Misaligned stream through the gearbox model
    reset_n = 1'b0;
    tick(1);
    sbase = slip_seen;
    gb_start = 5;
    gb_en = 1'b1;
    reset_n = 1'b1;
    for (int i = 0; i < 300 && !ready_o; i++) tick(1);
    chk("mis_lock", ready_o, 1);
    chk("mis_pulses", slip_seen - sbase, 5);
    chk("mis_slip_cnt", slip_cnt_o, 5);
    chk("mis_gap", gap_bad, 0);
    gb_en = 1'b0;

    // Reset asserted during a slip pulse
    dir_frame = '1;
    for (int i = 0; i < 50 && !bitslip_o; i++) tick(1);
    chk("midslip_seen", bitslip_o, 1);
    reset_n = 1'b0;
    tick(1);
    chk("midslip_bitslip", bitslip_o, 0);
    chk("midslip_ready", ready_o, 0);
    chk("midslip_valid", valid_o, 0);
    chk("midslip_frame", frame_o, 0);
    chk("midslip_slip", slip_cnt_o, 0);
    chk("midslip_err", err_cnt_o, 0);

    // Half-frame mode
    mode_i = 1'b0;
    dir_frame = {{128{1'b1}}, 2'b10, 126'h0ABC};
    reset_n = 1'b1;
    for (int i = 0; i < 50 && !ready_o; i++) tick(1);
    chk("half_lock", ready_o, 1);
    chk("half_valid_lag0", valid_o, 0);
    tick(1);
    chk("half_valid_lag1", valid_o, 1);
    chk("half_frame", frame_o, {128'd0, 2'b10, 126'h0ABC});
    chk("half_slip_cnt", slip_cnt_o, 0);

    // Mode toggle while locked; good header at both positions to time the relock
    dir_frame = {2'b10, 126'd0, 2'b10, 126'd0};
    tick(1);
    chk("toggle_pre_ready", ready_o, 1);
    mode_i = 1'b1;
    tick(1);
    chk("toggle_ready", ready_o, 0);
    for (int i = 1; i <= 8; i++) begin
      tick(1);
      if (i == 7) chk("relock_c7", ready_o, 0);
      if (i == 8) chk("relock_c8", ready_o, 1);
    end

    // 300 forced slips wrap the 8-bit counter to 44
    reset_n = 1'b0;
    dir_frame = '0;
    tick(1);
    sbase = slip_seen;
    reset_n = 1'b1;
    for (int i = 0; i < 3000 && (slip_seen - sbase) < 300; i++) tick(1);
    slips_at = slip_seen - sbase;
    chk("wrap_pulses", slips_at, 300);
    tick(2);
    chk("wrap_slip_cnt", slip_cnt_o, 44);
    enable_i = 1'b0;
    tick(2);
    chk("disable_ready", ready_o, 0);
    chk("overall_gap", gap_bad, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/frame_aligner_gen.md
FRAME_ALIGNER_GEN -- requirements
Module: frame_aligner_gen

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset.
REQ-002 Parameters (name, default, meaning), one per line:
- FRAME_W, 256: maximum frame width in bits.
- HDR_W, 2: header field width.
- HDR_PATTERN, 2'b10: expected header value.
- LOCK_THR, 8: consecutive good headers needed to lock, range 1..255.
- UNLOCK_THR, 4: consecutive bad headers needed to unlock, range 1..255.
- SLIP_WAIT, 3: settle cycles after each slip, range 0..15.
- ERR_W, 16: error counter width.
REQ-003 Ports (name, direction, width, meaning), one per line:
- clk40MHz_RX, in, 1: frame clock.
- reset_n, in, 1: synchronous active-low reset.
- enable_i, in, 1: aligner enable.
- mode_i, in, 1: 1 = full frame (FRAME_W bits), 0 = half frame (FRAME_W/2 bits, in the LSBs).
- frame_i, in, FRAME_W: parallel word from the gearbox, one per clock.
- bitslip_o, out, 1: one-cycle request for the gearbox to shift by one bit.
- ready_o, out, 1: aligner locked.
- frame_o, out, FRAME_W: registered frame.
- valid_o, out, 1: frame_o is valid.
- slip_cnt_o, out, 8: slips since the last reset, wrapping.
- err_cnt_o, out, ERR_W: header errors counted while locked.

Function
REQ-004 The header SHALL be frame_i[FRAME_W-1 -: HDR_W] when mode_i=1, else frame_i[FRAME_W/2-1 -: HDR_W].
REQ-005 A header is good when it equals HDR_PATTERN.
REQ-006 The FSM states SHALL be IDLE, CHECK, SLIP, WAIT, LOCKED.
REQ-007 IDLE: if enable_i=1, go to CHECK on the next clock.
REQ-008 In any state, enable_i=0 SHALL return the FSM to IDLE and clear good_cnt, bad_cnt and wait_cnt.
REQ-009 CHECK, good header: increment good_cnt; when good_cnt reaches LOCK_THR-1 with a good header, go to LOCKED.
REQ-010 CHECK, bad header: clear good_cnt and go to SLIP.
REQ-011 SLIP lasts exactly one cycle with bitslip_o=1, increments slip_cnt_o (wrapping 255->0), loads wait_cnt=SLIP_WAIT, then goes to WAIT.
REQ-012 bitslip_o SHALL be 1 only in SLIP, so slips are always separated by at least SLIP_WAIT+1 cycles.
REQ-013 WAIT: decrement wait_cnt and go to CHECK when it is 0; with SLIP_WAIT=0, SLIP goes directly to CHECK.
REQ-014 LOCKED: ready_o=1.
- Good header: clear bad_cnt.
- Bad header: increment bad_cnt.
- When bad_cnt reaches UNLOCK_THR-1 with a bad header: go to CHECK, clear good_cnt and bad_cnt, and set ready_o=0 on the following cycle.
REQ-015 A change in mode_i while ready_o=1 SHALL force CHECK on the next cycle and clear all counters.
REQ-016 frame_o SHALL equal frame_i delayed by one clock, with bits above FRAME_W/2 zeroed when mode_i=0.
REQ-017 valid_o SHALL be ready_o delayed by one clock, so it marks only frames taken while locked.
REQ-018 ready_o SHALL assert registered, on the clock after the LOCK_THR-th consecutive good header; latency from the first good header is LOCK_THR cycles.
REQ-019 err_cnt_o SHALL increment on each bad header while in LOCKED and saturate at all-ones.

Reset
REQ-020 reset_n=0 sampled on a rising clock edge SHALL set state=IDLE and drive bitslip_o=0, ready_o=0, valid_o=0, frame_o=0, slip_cnt_o=0 and err_cnt_o=0.
REQ-021 Reset asserted during SLIP SHALL drop bitslip_o on the next edge; no partial slip is counted.
REQ-022 Reset takes priority over enable_i and mode_i.

Configuration
REQ-023 The macro FRAME_ALIGNER_ERRCNT_EN SHALL gate the error counter.
- Defined: err_cnt_o behaves as REQ-019.
- Undefined: the counter logic is absent and err_cnt_o is tied to 0.
- All other behaviour is identical in both builds.

Verification
REQ-024 Aligned frames: mode_i=1, HDR_PATTERN at bits [255:254] every cycle, enable_i=1 -> ready_o=1 exactly 8 cycles after entering CHECK, bitslip_o never asserts, slip_cnt_o=0.
REQ-025 Misaligned stream: bench gearbox model starts at offset 5 and rotates one bit per bitslip_o -> exactly 5 slip pulses, each at least 4 cycles apart; slip_cnt_o=5; then lock.
REQ-026 Errors while locked: after lock, inject 3 bad headers then 1 good -> stays locked, err_cnt_o=3 (0 without the macro). Inject 4 consecutive bad -> ready_o falls, FSM goes to CHECK.
REQ-027 Half-frame mode: mode_i=0, header at [127:126] -> locks; frame_o[255:128]=0; valid_o lags ready_o by 1 cycle.
REQ-028 Boundaries:
- reset_n low for 1 cycle mid-SLIP -> all outputs 0 on the next cycle.
- mode_i toggled while locked -> ready_o=0 on the next cycle, counters cleared.
- Force 300 slips -> slip_cnt_o=44.
